// File: rtl/sliced_logic_unit.sv
// Multi-cycle bitwise logic unit: operands latched on start, SLICE bits processed per clock,
// result presented on a held register with a one-cycle done pulse.
module sliced_logic_unit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             carryout,
    output logic             overflow
);

    // state  | meaning
    // S_IDLE | waiting for start
    // S_RUN  | one slice of the latched operands written per cycle
    // S_DONE | result valid, done pulse; start here is accepted back-to-back
    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_mode;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_out;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    logic [SLICE-1:0] w_sa;
    logic [SLICE-1:0] w_sb;
    logic [SLICE-1:0] w_res;
    logic [WIDTH-1:0] w_work_next;

    assign w_last = (r_k == K_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Slice k of the operands, selected by equality compare so no index arithmetic on r_k
    always_comb begin
        w_sa = '0;
        w_sb = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (r_k == KW'(i)) begin
                w_sa = r_a[i*SLICE +: SLICE];
                w_sb = r_b[i*SLICE +: SLICE];
            end
        end
    end

    always_comb begin
        case (r_mode)
            3'd0:    w_res = ~(w_sa & w_sb);
            3'd1:    w_res =   w_sa & w_sb;
            3'd2:    w_res = ~(w_sa | w_sb);
            3'd3:    w_res =   w_sa | w_sb;
            3'd4:    w_res = ~(w_sa ^ w_sb);
            3'd5:    w_res =   w_sa ^ w_sb;
            3'd6:    w_res =   w_sa;
            default: w_res =  ~w_sa;
        endcase
    end

    always_comb begin
        w_work_next = r_work;
        for (int i = 0; i < NSLICE; i++) begin
            if (r_k == KW'(i)) begin
                w_work_next[i*SLICE +: SLICE] = w_res;
            end
        end
    end

    // out/zero load from the merged word on the last slice, so they never show a partial result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_mode <= '0;
            r_k    <= '0;
            r_work <= '0;
            r_out  <= '0;
            r_zero <= 1'b1;
        end else if (w_accept) begin
            r_a    <= a;
            r_b    <= b;
            r_mode <= mode;
            r_k    <= '0;
            r_work <= '0;
        end else if (r_state == S_RUN) begin
            r_work <= w_work_next;
            if (w_last) begin
                r_out  <= w_work_next;
                r_zero <= (w_work_next == '0);
            end else begin
                r_k <= r_k + 1'b1;
            end
        end
    end

    assign out      = r_out;
    assign zero     = r_zero;
    assign carryout = 1'b0;
    assign overflow = 1'b0;

endmodule

// File: tb/tb_sliced_logic_unit.sv
// Self-checking bench for sliced_logic_unit: three parameterisations driven from shared operand
// buses, compared against a whole-word behavioural model of the eight logic modes.
module tb_sliced_logic_unit;

    logic        clk;
    logic        reset_n;
    logic [63:0] tb_a;
    logic [63:0] tb_b;
    logic [2:0]  tb_mode;
    logic [2:0]  tb_start;

    logic        busy32, done32, zero32, cout32, ovf32;
    logic [31:0] out32;
    logic        busy16, done16, zero16, cout16, ovf16;
    logic [15:0] out16;
    logic        busy64, done64, zero64, cout64, ovf64;
    logic [63:0] out64;

    int          sel;
    logic        s_busy, s_done, s_zero, s_cout, s_ovf;
    logic [63:0] s_out;

    int checks = 0;
    int errors = 0;

    sliced_logic_unit #(.WIDTH(32), .SLICE(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(tb_start[0]),
        .a(tb_a[31:0]), .b(tb_b[31:0]), .mode(tb_mode),
        .busy(busy32), .done(done32), .out(out32), .zero(zero32),
        .carryout(cout32), .overflow(ovf32)
    );

    sliced_logic_unit #(.WIDTH(16), .SLICE(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .start(tb_start[1]),
        .a(tb_a[15:0]), .b(tb_b[15:0]), .mode(tb_mode),
        .busy(busy16), .done(done16), .out(out16), .zero(zero16),
        .carryout(cout16), .overflow(ovf16)
    );

    sliced_logic_unit #(.WIDTH(64), .SLICE(4)) dut64 (
        .clk(clk), .reset_n(reset_n), .start(tb_start[2]),
        .a(tb_a), .b(tb_b), .mode(tb_mode),
        .busy(busy64), .done(done64), .out(out64), .zero(zero64),
        .carryout(cout64), .overflow(ovf64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (sel)
            1: begin
                s_busy = busy16; s_done = done16; s_zero = zero16;
                s_cout = cout16; s_ovf = ovf16; s_out = {48'd0, out16};
            end
            2: begin
                s_busy = busy64; s_done = done64; s_zero = zero64;
                s_cout = cout64; s_ovf = ovf64; s_out = out64;
            end
            default: begin
                s_busy = busy32; s_done = done32; s_zero = zero32;
                s_cout = cout32; s_ovf = ovf32; s_out = {32'd0, out32};
            end
        endcase
    end

    function automatic int width_of(input int s);
        return (s == 1) ? 16 : ((s == 2) ? 64 : 32);
    endfunction

    function automatic int nslice_of(input int s);
        return (s == 1) ? 1 : ((s == 2) ? 16 : 4);
    endfunction

    function automatic logic [63:0] ref_op(input int w, input logic [2:0] m,
                                           input logic [63:0] x, input logic [63:0] y);
        logic [63:0] mask;
        logic [63:0] r;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        case (m)
            3'd0: r = ~(x & y);
            3'd1: r = x & y;
            3'd2: r = ~(x | y);
            3'd3: r = x | y;
            3'd4: r = ~(x ^ y);
            3'd5: r = x ^ y;
            3'd6: r = x;
            default: r = ~x;
        endcase
        return r & mask;
    endfunction

    task automatic run_op(input int s, input logic [2:0] m, input logic [63:0] av,
                          input logic [63:0] bv, input string name);
        logic [63:0] exp;
        logic [63:0] prev_out;
        int lat, busy_cnt, held_bad;
        sel = s;
        exp = ref_op(width_of(s), m, av, bv);
        lat = -1; busy_cnt = 0; held_bad = 0;
        @(negedge clk);
        prev_out = s_out;
        tb_a = av; tb_b = bv; tb_mode = m; tb_start[s] = 1'b1;
        @(posedge clk); #1;
        tb_start[s] = 1'b0;
        tb_a = {$urandom, $urandom}; tb_b = {$urandom, $urandom};
        tb_mode = 3'($urandom_range(7));
        for (int c = 0; c < 40; c++) begin
            if (s_done) begin
                lat = c;
                break;
            end
            if (s_busy) busy_cnt++;
            if (s_out !== prev_out) held_bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (lat !== nslice_of(s)) begin
            errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, nslice_of(s));
        end
        checks++;
        if (busy_cnt !== nslice_of(s)) begin
            errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, nslice_of(s));
        end
        checks++;
        if (held_bad !== 0) begin
            errors++; $display("FAIL %s out_held_while_busy: %0d changed cycles, expected 0", name, held_bad);
        end
        checks++;
        if (s_out !== exp) begin
            errors++; $display("FAIL %s out: got %h expected %h", name, s_out, exp);
        end
        checks++;
        if (s_zero !== (exp == 64'd0)) begin
            errors++; $display("FAIL %s zero: got %b expected %b", name, s_zero, (exp == 64'd0));
        end
        checks++;
        if ({s_cout, s_ovf} !== 2'b00) begin
            errors++; $display("FAIL %s carry_ovf: got %b expected 00", name, {s_cout, s_ovf});
        end
        @(posedge clk); #1;
        checks++;
        if ({s_done, s_busy} !== 2'b00) begin
            errors++; $display("FAIL %s done_one_cycle: done/busy %b expected 00", name, {s_done, s_busy});
        end
        checks++;
        if (s_out !== exp) begin
            errors++; $display("FAIL %s out_hold_after: got %h expected %h", name, s_out, exp);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sel = 0;
        checks++;
        if ({busy32, done32, zero32, cout32, ovf32} !== 5'b00100) begin
            errors++; $display("FAIL reset_flags: got %b expected 00100", {busy32, done32, zero32, cout32, ovf32});
        end
        checks++;
        if (out32 !== 32'd0) begin
            errors++; $display("FAIL reset_out: got %h expected 0", out32);
        end
        checks++;
        if ({out64, zero64, busy64} !== {64'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL reset_out64: out %h zero %b busy %b expected 0/1/0", out64, zero64, busy64);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_nand();
        run_op(0, 3'd0, 64'hFFFFFFFE, 64'hC0D1FE0E, "nand");
        checks++;
        if (out32 !== 32'h3F2E01F1) begin
            errors++; $display("FAIL nand_const: got %h expected 3f2e01f1", out32);
        end
    endtask

    task automatic test_and_zero();
        run_op(0, 3'd1, 64'hFFFFFFFE, 64'hC0D1FE0E, "and");
        run_op(0, 3'd1, 64'hF0F0F0F0, 64'h0F0F0F0F, "and_zero");
        checks++;
        if ({out32, zero32} !== {32'd0, 1'b1}) begin
            errors++; $display("FAIL and_zero_const: out %h zero %b expected 0/1", out32, zero32);
        end
    endtask

    task automatic test_start_during_busy();
        logic [63:0] exp;
        logic [31:0] got;
        int done_cnt;
        sel = 0;
        done_cnt = 0; got = '0;
        exp = ref_op(32, 3'd5, 64'hFFFF0000, 64'hFF00FF00);
        @(negedge clk);
        tb_a = 64'hFFFF0000; tb_b = 64'hFF00FF00; tb_mode = 3'd5; tb_start[0] = 1'b1;
        @(posedge clk); #1;
        tb_start[0] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            tb_start[0] = (c == 1);
            if (c == 1) begin
                tb_a = 64'd0; tb_b = 64'd0;
            end
            @(posedge clk); #1;
            if (done32) begin
                done_cnt++;
                got = out32;
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++; $display("FAIL busy_start_done_count: got %0d expected 1", done_cnt);
        end
        checks++;
        if (got !== exp[31:0]) begin
            errors++; $display("FAIL busy_start_out: got %h expected %h", got, exp[31:0]);
        end
        checks++;
        if (out32 !== 32'h00FFFF00) begin
            errors++; $display("FAIL busy_start_const: got %h expected 00ffff00", out32);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp;
        int done_idx[$];
        int busy_bad, out_bad;
        sel = 0;
        busy_bad = 0; out_bad = 0;
        exp = ref_op(32, 3'd3, 64'h0000FFFF, 64'h12340000);
        @(negedge clk);
        tb_a = 64'h0000FFFF; tb_b = 64'h12340000; tb_mode = 3'd3; tb_start[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (busy32 !== !done32) busy_bad++;
            if (done32) begin
                done_idx.push_back(c);
                if (out32 !== exp[31:0]) out_bad++;
            end
        end
        @(negedge clk);
        tb_start[0] = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done_idx.size() !== 4) begin
            errors++; $display("FAIL b2b_done_count: got %0d expected 4", done_idx.size());
        end
        for (int i = 0; i < done_idx.size(); i++) begin
            checks++;
            if (done_idx[i] !== 4 + 5 * i) begin
                errors++; $display("FAIL b2b_done_cycle%0d: got %0d expected %0d", i, done_idx[i], 4 + 5 * i);
            end
        end
        checks++;
        if (busy_bad !== 0) begin
            errors++; $display("FAIL b2b_busy_pattern: %0d bad cycles expected 0", busy_bad);
        end
        checks++;
        if (out_bad !== 0) begin
            errors++; $display("FAIL b2b_out: %0d wrong results expected 0", out_bad);
        end
        checks++;
        if ({busy32, done32} !== 2'b00) begin
            errors++; $display("FAIL b2b_idle_after: busy/done %b expected 00", {busy32, done32});
        end
    endtask

    task automatic test_reset_midrun();
        int done_cnt;
        sel = 0;
        done_cnt = 0;
        @(negedge clk);
        tb_a = 64'hDEADBEEF; tb_b = 64'hFFFF0000; tb_mode = 3'd1; tb_start[0] = 1'b1;
        @(posedge clk); #1;
        tb_start[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy32, done32, zero32} !== 3'b001) begin
            errors++; $display("FAIL midrun_reset_flags: got %b expected 001", {busy32, done32, zero32});
        end
        checks++;
        if (out32 !== 32'd0) begin
            errors++; $display("FAIL midrun_reset_out: got %h expected 0", out32);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done32 || busy32) done_cnt++;
        end
        checks++;
        if (done_cnt !== 0) begin
            errors++; $display("FAIL midrun_no_done: %0d active cycles expected 0", done_cnt);
        end
        run_op(0, 3'd1, 64'hDEADBEEF, 64'hFFFF0000, "after_reset");
    endtask

    task automatic test_random_default();
        for (int i = 0; i < 16; i++) begin
            run_op(0, 3'(i % 8), {32'd0, $urandom}, {32'd0, $urandom}, "rand32");
        end
    endtask

    task automatic test_param_sweep();
        for (int i = 0; i < 16; i++) begin
            run_op(1, 3'(i % 8), {$urandom, $urandom}, {$urandom, $urandom}, "sweep16");
        end
        for (int i = 0; i < 16; i++) begin
            run_op(2, 3'(i % 8), {$urandom, $urandom}, {$urandom, $urandom}, "sweep64");
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        tb_start = 3'b000;
        tb_a     = '0;
        tb_b     = '0;
        tb_mode  = '0;
        sel      = 0;
        test_reset();
        test_nand();
        test_and_zero();
        test_start_during_busy();
        test_back_to_back();
        test_reset_midrun();
        test_random_default();
        test_param_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sliced_logic_unit.md
# sliced_logic_unit

Parametrised, multi-cycle bitwise logic unit: the successor to the 32-bit combinational AND/NAND block in the ALU datapath. It is generalised to WIDTH bits and eight logic modes. Operands are latched on a start pulse and processed SLICE bits per clock, so wide words do not create a long combinational path. The result is presented on a held output register with a one-cycle done pulse and flags compatible with the ALU's carryout/overflow outputs.

## Interface
- WIDTH, 32, operand/result width in bits; must be an integer multiple of SLICE.
- SLICE, 8, bits processed per clock; NSLICE = WIDTH/SLICE cycles per operation.
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset; clears all state immediately.
- start  input  1  request an operation; sampled only when accepted (see Operation).
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- mode  input  3  operation select; latched on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; out/zero are valid from this cycle on.
- out  output  WIDTH  result register; holds the last completed result.
- zero  output  1  high when the last completed result is all zeros.
- carryout  output  1  constant 0 (logic ops never carry).
- overflow  output  1  constant 0.

## Operation
- Mode encoding:
  - 0 NAND, 1 AND: keeps compatibility with the old andflag, where 0 = NAND and 1 = AND.
  - 2 NOR, 3 OR, 4 XNOR, 5 XOR.
  - 6 PASS A, 7 NOT A.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 latches a, b and mode into operand registers, clears the slice counter and goes to RUN. start=0 stays in IDLE.
  - RUN: each cycle computes slice k (bits k*SLICE+SLICE-1 down to k*SLICE) from the latched operands into a working register, then increments k.
  - RUN exit: after slice NSLICE-1 is written, the working register is copied to out, zero is updated, and the FSM goes to DONE.
  - DONE: done=1 for exactly one cycle. start=1 in DONE is accepted (back-to-back) and goes to RUN with new operands; otherwise the FSM goes to IDLE.
- start during RUN is ignored. No queueing; the operands in flight are unaffected.
- Changes on a, b or mode after acceptance have no effect.
- out and zero change only at completion. They are never partially updated while busy.
- Reset values (asynchronous, while reset_n=0):
  - state=IDLE, busy=0, done=0, out=0, zero=1.
  - carryout=0, overflow=0, slice counter=0, operand and working registers=0.
- Reset during RUN abandons the operation. No done is produced and out returns to 0.

## Timing
- Call the rising edge that accepts start E0.
- busy is high in the NSLICE cycles following E0.
- Slice k is written at edge E(k+1).
- out, zero and done are updated at edge E(NSLICE). done is high for the single cycle after that edge.
- Latency from start acceptance to done is NSLICE cycles; for the defaults, done rises 4 cycles after E0.
- With SLICE = WIDTH, latency is 1 cycle, with RUN lasting one cycle.
- Throughput with back-to-back starts: one result per NSLICE+1 cycles.
- Slice counter width is clog2(NSLICE), minimum 1 bit. The counter never wraps inside an operation.

## Test plan
- NAND, defaults. Stimulus: mode=0, a=0xFFFFFFFE, b=0xC0D1FE0E, 1-cycle start. Response: busy high 4 cycles; done 4 cycles after E0; out=0x3F2E01F1; zero=0; carryout=overflow=0.
- AND/zero flag. Stimulus: mode=1, same operands. Response: out=0xC0D1FE0E. Then a=0xF0F0F0F0, b=0x0F0F0F0F, mode=1. Response: out=0, zero=1.
- XOR and start during busy. Stimulus: mode=5, a=0xFFFF0000, b=0xFF00FF00; two cycles later, start with a=0, b=0. Response: second start ignored, exactly one done, out=0x00FFFF00.
- Back-to-back. Stimulus: start held high continuously, mode=3 (OR), a=0x0000FFFF, b=0x12340000. Response: done every 5 cycles, out=0x1234FFFF each time, busy low only during DONE cycles.
- Reset mid-run. Stimulus: reset_n low 2 cycles after E0 of an AND operation. Response: immediately busy=0, done=0, out=0, zero=1. No done follows; the next start completes normally.
- Parameter sweep. Stimulus: WIDTH=16/SLICE=16, and WIDTH=64/SLICE=4, random a, b and all 8 modes. Response: latency 1 and 16 respectively; out matches the golden bitwise result for every mode.
